// File: rtl/uart_tx_sequencer.sv
// Byte FIFO plus start/ack/complete sequencer feeding TXBlock; 2 cycles push-to-DATA, 3 to CONTROL=FF.
// Writes while full are dropped and flagged in ovf_o; a start is held off until TXBlock reports idle.
module uart_tx_sequencer #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          clr_i,
  input  logic [7:0]    tx_status_i,
  output logic [7:0]    tx_control_o,
  output logic [7:0]    tx_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          busy_o,
  output logic          ovf_o,
  output logic          err_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    ctrl_q, ctrl_d, data_q, data_d;
  logic [CW-1:0] ack_q, ack_d;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic          full_w, empty_w, push, pop, err_evt;

  assign full_w  = (count_q == DEPTH_W);
  assign empty_w = (count_q == '0);

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    ack_d   = ack_q;
    pop     = 1'b0;
    err_evt = 1'b0;
    case (state_q)
      IDLE: begin
        // Wait for TXBlock idle too, so a frame left over from reset is not clobbered.
        if (!empty_w && tx_status_i == 8'h00) begin
          data_d  = mem_q[rd_ptr_q];
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ctrl_d  = 8'hFF;
        ack_d   = '0;
        state_d = REQ;
      end
      REQ: begin
        if (tx_status_i == 8'hFF) begin
          ctrl_d  = 8'h00;
          state_d = WAIT_DONE;
        end else if (ack_q == ACK_LAST) begin
          err_evt = 1'b1;
          ctrl_d  = 8'h00;
          state_d = IDLE;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_status_i == 8'h00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push     = wr_en_i && !full_w;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new event outranks a coincident clear.
    ovf_d = (ovf_q && !clr_i) || (wr_en_i && full_w);
    err_d = (err_q && !clr_i) || err_evt;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ctrl_q   <= 8'h00;
      data_q   <= 8'h00;
      ack_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign tx_control_o = ctrl_q;
  assign tx_data_o    = data_q;
  assign full_o       = full_w;
  assign empty_o      = empty_w;
  assign count_o      = count_q;
  assign busy_o       = (state_q != IDLE);
  assign ovf_o        = ovf_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a small TXBlock responder.
module tb_uart_tx_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1, wr_en = 1'b0, clr = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic [7:0]    tx_status, tx_control, tx_data;
  logic          full, empty, busy, ovf, err;
  logic [AW:0]   count;

  int n_vec = 0;
  int n_err = 0;

  logic       auto_mode = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic [7:0] model_status = 8'h00;
  int         m_cnt = 0;
  int         model_viol = 0;
  logic [7:0] rx_q[$];

  assign tx_status = auto_mode ? model_status : force_val;

  always #5 clk = ~clk;

  uart_tx_sequencer #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .clr_i(clr),
    .tx_status_i(tx_status), .tx_control_o(tx_control), .tx_data_o(tx_data),
    .full_o(full), .empty_o(empty), .count_o(count), .busy_o(busy),
    .ovf_o(ovf), .err_o(err)
  );

  // TXBlock responder: accepts on CONTROL=FF, stays busy 4 cycles, then reports done.
  always @(negedge clk) begin
    if (!auto_mode) begin
      model_status = 8'h00;
      m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        if (tx_control !== 8'h00) model_viol = model_viol + 1;
        model_status = 8'h00;
      end
    end else if (tx_control == 8'hFF) begin
      rx_q.push_back(tx_data);
      model_status = 8'hFF;
      m_cnt = 4;
    end else begin
      model_status = 8'h00;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    model_viol = 0;
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = base + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic drain(input int expect_n);
    int k;
    auto_mode = 1'b1;
    k = 0;
    while (!(rx_q.size() == expect_n && !busy && empty) && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 400) begin n_err++; $display("FAIL drain_timeout: got %0d bytes, required %0d", rx_q.size(), expect_n); end
    auto_mode = 1'b0;
  endtask

  task automatic test_reset();
    force_val = 8'h00; auto_mode = 1'b0;
    do_reset();
    n_vec++; if (tx_control !== 8'h00) begin n_err++; $display("FAIL reset_ctrl: got %h required 00", tx_control); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h required 00", tx_data); end
    n_vec++; if ({full, empty, busy} !== 3'b010) begin n_err++; $display("FAIL reset_flags: full/empty/busy got %b required 010", {full, empty, busy}); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", count); end
    n_vec++; if ({ovf, err} !== 2'b00) begin n_err++; $display("FAIL reset_sticky: ovf/err got %b required 00", {ovf, err}); end
  endtask

  task automatic test_single_byte();
    force_val = 8'h00; auto_mode = 1'b0;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h4E;
    @(negedge clk); wr_en = 1'b0;
    n_vec++; if (count !== 4'd1 || empty !== 1'b0) begin n_err++; $display("FAIL single_push: count %0d empty %b required 1 0", count, empty); end
    @(negedge clk);
    n_vec++; if (tx_data !== 8'h4E || tx_control !== 8'h00) begin n_err++; $display("FAIL single_data: data %h ctrl %h required 4e 00", tx_data, tx_control); end
    @(negedge clk);
    n_vec++; if (tx_control !== 8'hFF) begin n_err++; $display("FAIL single_start: ctrl %h required ff", tx_control); end
    force_val = 8'hFF;
    @(negedge clk);
    n_vec++; if (tx_control !== 8'h00 || busy !== 1'b1) begin n_err++; $display("FAIL single_ack: ctrl %h busy %b required 00 1", tx_control, busy); end
    force_val = 8'h00;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || empty !== 1'b1 || tx_data !== 8'h4E) begin n_err++; $display("FAIL single_done: busy %b empty %b data %h required 0 1 4e", busy, empty, tx_data); end
  endtask

  task automatic test_burst();
    force_val = 8'hFF; auto_mode = 1'b0;
    do_reset();
    push_bytes(8'h01, 8);
    n_vec++; if (full !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL burst_full: full %b count %0d required 1 8", full, count); end
    drain(8);
    n_vec++; if (rx_q.size() != 8) begin n_err++; $display("FAIL burst_size: got %0d required 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[i] !== 8'(i + 1)) begin n_err++; $display("FAIL burst_order[%0d]: got %h required %h", i, rx_q[i], 8'(i + 1)); end
    end
    n_vec++; if (model_viol != 0) begin n_err++; $display("FAIL burst_ctrl_release: %0d frames ended with control not 00, required 0", model_viol); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL burst_ovf: got %b required 0", ovf); end
  endtask

  task automatic test_overflow();
    force_val = 8'hFF; auto_mode = 1'b0;
    do_reset();
    push_bytes(8'h10, 8);
    wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk); wr_en = 1'b0;
    n_vec++; if (ovf !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL ovf_set: ovf %b count %0d required 1 8", ovf, count); end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b required 0", ovf); end
    clr = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk); clr = 1'b0; wr_en = 1'b0;
    n_vec++; if (ovf !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL ovf_clr_collide: ovf %b count %0d required 1 8", ovf, count); end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr2: got %b required 0", ovf); end
    drain(8);
    n_vec++; if (rx_q.size() != 8) begin n_err++; $display("FAIL ovf_drain_size: got %0d required 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[i] !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL ovf_order[%0d]: got %h required %h", i, rx_q[i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_timeout();
    int k;
    force_val = 8'h00; auto_mode = 1'b0;
    do_reset();
    push_bytes(8'h5A, 1);
    push_bytes(8'h6B, 1);
    k = 0;
    while (tx_control !== 8'hFF && k < 10) begin @(negedge clk); k++; end
    n_vec++; if (k >= 10 || tx_data !== 8'h5A) begin n_err++; $display("FAIL to_start: ctrl %h data %h required ff 5a", tx_control, tx_data); end
    for (int i = 1; i < 64; i++) @(negedge clk);
    n_vec++; if (tx_control !== 8'hFF || err !== 1'b0) begin n_err++; $display("FAIL to_early: after 63 cycles ctrl %h err %b required ff 0", tx_control, err); end
    @(negedge clk);
    n_vec++; if (tx_control !== 8'h00 || err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL to_fire: ctrl %h err %b busy %b required 00 1 0", tx_control, err, busy); end
    n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL to_count: got %0d required 1", count); end
    @(negedge clk);
    n_vec++; if (tx_data !== 8'h6B) begin n_err++; $display("FAIL to_next_data: got %h required 6b", tx_data); end
    @(negedge clk);
    n_vec++; if (tx_control !== 8'hFF) begin n_err++; $display("FAIL to_next_start: got %h required ff", tx_control); end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL to_clr: got %b required 0", err); end
  endtask

  task automatic test_reset_mid_frame();
    force_val = 8'h00; auto_mode = 1'b0;
    do_reset();
    push_bytes(8'hA1, 4);
    n_vec++; if (tx_control !== 8'hFF || count !== 4'd3) begin n_err++; $display("FAIL rst_setup: ctrl %h count %0d required ff 3", tx_control, count); end
    force_val = 8'hFF;
    @(negedge clk);
    n_vec++; if (tx_control !== 8'h00 || busy !== 1'b1 || count !== 4'd3) begin n_err++; $display("FAIL rst_wait: ctrl %h busy %b count %0d required 00 1 3", tx_control, busy, count); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_vec++; if (count !== 4'd0 || tx_control !== 8'h00 || busy !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL rst_mid: count %0d ctrl %h busy %b empty %b required 0 00 0 1", count, tx_control, busy, empty); end
    push_bytes(8'hB1, 1);
    repeat (5) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || count !== 4'd1 || tx_control !== 8'h00) begin n_err++; $display("FAIL rst_hold: busy %b count %0d ctrl %h required 0 1 00", busy, count, tx_control); end
    force_val = 8'h00;
    @(negedge clk);
    n_vec++; if (tx_data !== 8'hB1 || busy !== 1'b1) begin n_err++; $display("FAIL rst_resume_data: data %h busy %b required b1 1", tx_data, busy); end
    @(negedge clk);
    n_vec++; if (tx_control !== 8'hFF) begin n_err++; $display("FAIL rst_resume_start: got %h required ff", tx_control); end
  endtask

  task automatic test_wrap();
    int exp_cnt, pushed, ref_st, both;
    logic do_push, do_pop;
    logic [7:0] st;
    bit done;
    force_val = 8'h00; auto_mode = 1'b0;
    do_reset();
    auto_mode = 1'b1;
    exp_cnt = 0; pushed = 0; ref_st = 0; both = 0; done = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_vec++; if (count !== 4'(exp_cnt)) begin n_err++; $display("FAIL wrap_count cyc %0d: got %0d required %0d", cyc, count, exp_cnt); end
      if (pushed == 20 && exp_cnt == 0 && ref_st == 0) begin done = 1'b1; break; end
      do_push = (pushed < 20) && (exp_cnt < DEPTH) && (cyc % 3 != 2);
      wr_en = do_push; wr_data = 8'h30 + 8'(pushed);
      @(posedge clk);
      st = tx_status;
      do_pop = (ref_st == 0) && (exp_cnt != 0) && (st == 8'h00);
      if (do_push && do_pop) both++;
      exp_cnt = exp_cnt + int'(do_push) - int'(do_pop);
      pushed = pushed + int'(do_push);
      case (ref_st)
        0: if (do_pop) ref_st = 1;
        1: ref_st = 2;
        2: if (st == 8'hFF) ref_st = 3;
        default: if (st == 8'h00) ref_st = 0;
      endcase
    end
    wr_en = 1'b0;
    auto_mode = 1'b0;
    n_vec++; if (!done) begin n_err++; $display("FAIL wrap_timeout: pushed %0d expected count %0d", pushed, exp_cnt); end
    n_vec++; if (rx_q.size() != 20) begin n_err++; $display("FAIL wrap_size: got %0d required 20", rx_q.size()); end
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      n_vec++; if (rx_q[i] !== 8'h30 + 8'(i)) begin n_err++; $display("FAIL wrap_order[%0d]: got %h required %h", i, rx_q[i], 8'h30 + 8'(i)); end
    end
    $display("wrap: %0d cycles with simultaneous push and pop", both);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Byte-queue and handshake controller in front of the UART transmitter (`TXBlock`). Software or the CPU bus pushes bytes into an internal FIFO; the sequencer pops them one at a time, drives `TXBlock`'s `DATA`/`CONTROL` inputs, and watches `STATUS` to pace transmission. It removes the per-byte start/acknowledge/complete handshake from the CPU and flags overflow and acknowledge timeouts.

## Interface
- `DEPTH`, 8: FIFO depth in bytes. Must be a power of two, ≥2.
- `AW`, 3: pointer width, log2(`DEPTH`).
- `ACK_TIMEOUT`, 64: cycles allowed in REQ for `TX_STATUS` to read 8'hFF.
- `CLK` in 1: single clock; all logic on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `WR_EN` in 1: push `WR_DATA` this cycle.
- `WR_DATA` in 8: byte to queue.
- `CLR` in 1: clears the sticky `OVF` and `ERR` flags.
- `TX_STATUS` in 8: `TXBlock` `STATUS`.
- `TX_CONTROL` out 8: to `TXBlock` `CONTROL`. 8'hFF means start; 8'h00 means idle.
- `TX_DATA` out 8: to `TXBlock` `DATA`.
- `FULL` out 1: FIFO holds `DEPTH` bytes.
- `EMPTY` out 1: FIFO holds 0 bytes.
- `COUNT` out AW+1: FIFO occupancy.
- `BUSY` out 1: FSM is not in IDLE.
- `OVF` out 1: sticky. A write was attempted while `FULL`.
- `ERR` out 1: sticky. An acknowledge timeout occurred.

## Operation
- `TXBlock` protocol:
  - `DATA` is stable ≥1 cycle before `CONTROL`=8'hFF.
  - `TXBlock` answers `STATUS`=8'hFF (accepted/busy).
  - The controller then returns `CONTROL` to 8'h00.
  - `STATUS`=8'h00 means the frame is complete and the line is idle.
- FIFO:
  - Circular buffer with `AW`-bit read/write pointers; pointers wrap modulo `DEPTH`.
  - `COUNT` is tracked explicitly.
  - Write when `WR_EN` && !`FULL`.
  - A write while `FULL` is dropped and sets `OVF`, even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop leaves `COUNT` unchanged.
- FSM states: IDLE, LOAD, REQ, WAIT_DONE.
  - IDLE: if !`EMPTY` and `TX_STATUS`==8'h00, register the head byte into `TX_DATA`, pop, and go to LOAD. Otherwise stay.
  - LOAD: set `TX_CONTROL`=8'hFF, clear the ack counter, go to REQ.
  - REQ: if `TX_STATUS`==8'hFF, set `TX_CONTROL`=8'h00 and go to WAIT_DONE.
    - Otherwise increment the ack counter.
    - When the counter reaches `ACK_TIMEOUT`-1: set `ERR`, set `TX_CONTROL`=8'h00, discard the byte, go to IDLE.
    - `TX_STATUS` values other than 8'h00 and 8'hFF count as not-acknowledged.
  - WAIT_DONE: when `TX_STATUS`==8'h00, go to IDLE. `TX_DATA` is held throughout.
- `TX_DATA` changes only on the IDLE→LOAD transition.
- `CLR` clears `OVF`/`ERR`. If `CLR` coincides with a new overflow or timeout event, the event wins and the flag stays set.
- Reset mid-operation:
  - FIFO is emptied; FSM goes to IDLE; `TX_CONTROL`=0.
  - The in-flight byte is abandoned; `TXBlock` is not reset and may finish its frame.
  - The IDLE `TX_STATUS`==8'h00 guard prevents a new start until it does.

## Timing
- Reset values:
  - `TX_CONTROL`=8'h00, `TX_DATA`=8'h00.
  - `FULL`=0, `EMPTY`=1, `COUNT`=0, `BUSY`=0.
  - `OVF`=0, `ERR`=0.
  - FSM in IDLE.
- All outputs are registered; no combinational input→output paths.
- Push latency: after `WR_EN` is sampled at edge k, `COUNT`/`EMPTY` update at edge k.
- Start latency:
  - With FSM idle and `TX_STATUS`=0: `TX_DATA` is valid after edge k+1 and `TX_CONTROL`=8'hFF after edge k+2.
- Handshake latency:
  - `TX_STATUS`=8'hFF sampled at edge m gives `TX_CONTROL`=8'h00 after edge m.
  - `TX_STATUS`=8'h00 sampled in WAIT_DONE at edge n gives IDLE after edge n.
  - The next byte's `TX_DATA` follows at edge n+1 at the earliest.
- Back-to-back bytes incur a minimum of 3 cycles of controller overhead beyond `TXBlock` frame time.
- Timeout: `ERR` is set and `TX_CONTROL` returns to 0 exactly `ACK_TIMEOUT` cycles after `TX_CONTROL` first reads 8'hFF.

## Test plan
- **Single byte.** Reset, push 8'h4E.
  - `TX_DATA`=8'h4E after 2 edges; `TX_CONTROL`=8'hFF after 3.
  - Model drives `STATUS`=FF: `CONTROL`=0 the next cycle.
  - Model drives `STATUS`=0: `BUSY`=0 and `EMPTY`=1.
- **Burst.** Push 8 bytes 8'h01..8'h08 back-to-back with DEPTH=8.
  - `FULL`=1 after the 8th push.
  - `TXBlock` model observes bytes 01..08 in order, each with `CONTROL` FF→00.
  - `OVF`=0 throughout.
- **Overflow.**
  - Hold `STATUS`=FF so nothing drains, fill the FIFO, push 8'hAA: `OVF`=1, `COUNT`=`DEPTH`, 8'hAA is never transmitted.
  - Pulse `CLR`: `OVF`=0.
- **Timeout.** Model never asserts `STATUS`=FF.
  - `ERR`=1 and `TX_CONTROL`=0 exactly 64 cycles after start.
  - The next queued byte is then attempted.
- **Reset mid-frame.**
  - Assert `RST` in WAIT_DONE with 3 bytes queued: next cycle `COUNT`=0, `TX_CONTROL`=0, `BUSY`=0.
  - While the model keeps `STATUS`=FF, a push does not start until `STATUS`=0.
- **Wrap and simultaneous push/pop.** Stream 20 bytes through DEPTH=8, pushing on the same cycle as pops.
  - `COUNT` is correct every cycle.
  - Output order matches input order across pointer wrap.
